// File: rtl/axi_lite_manager.sv
// -----------------------------------------------------------------------------
// axi_lite_manager
// AXI4-Lite manager. Turns a single-beat command/response handshake into one
// AXI-Lite read or write transaction at a time. Every AXI output is a flop.
//
// Ports
//   axi_aclk_in / axi_areset_in : clock, synchronous active-high reset
//   cmd_*                       : command request (valid/ready, write flag,
//                                 address, write data, byte strobes)
//   rsp_*                       : response (valid/ready, read data, resp code)
//   axi_aw* / axi_w* / axi_b*   : AXI-Lite write address, data, response
//   axi_ar* / axi_r*            : AXI-Lite read address, read data
// -----------------------------------------------------------------------------
module axi_lite_manager #(
  parameter int         DATA_WIDTH    = 32,
  parameter int         ADDRESS_WIDTH = 4,
  parameter logic [2:0] PROT          = 3'b000
) (
  input  logic                      axi_aclk_in,
  input  logic                      axi_areset_in,
  // command side
  input  logic                      cmd_valid_in,
  output logic                      cmd_ready_out,
  input  logic                      cmd_write_in,
  input  logic [ADDRESS_WIDTH-1:0]  cmd_addr_in,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata_in,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb_in,
  // response side
  output logic                      rsp_valid_out,
  input  logic                      rsp_ready_in,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_out,
  output logic [1:0]                rsp_resp_out,
  // AXI write address
  output logic [ADDRESS_WIDTH-1:0]  axi_awaddr_out,
  output logic [2:0]                axi_awprot_out,
  output logic                      axi_awvalid_out,
  input  logic                      axi_awready_in,
  // AXI write data
  output logic [DATA_WIDTH-1:0]     axi_wdata_out,
  output logic [DATA_WIDTH/8-1:0]   axi_wstrb_out,
  output logic                      axi_wvalid_out,
  input  logic                      axi_wready_in,
  // AXI write response
  input  logic [1:0]                axi_bresp_in,
  input  logic                      axi_bvalid_in,
  output logic                      axi_bready_out,
  // AXI read address
  output logic [ADDRESS_WIDTH-1:0]  axi_araddr_out,
  output logic [2:0]                axi_arprot_out,
  output logic                      axi_arvalid_out,
  input  logic                      axi_arready_in,
  // AXI read data
  input  logic [DATA_WIDTH-1:0]     axi_rdata_in,
  input  logic [1:0]                axi_rresp_in,
  input  logic                      axi_rvalid_in,
  output logic                      axi_rready_out
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RESPOND      = 3'd5
  } state_t;

  state_t                     state_r;
  logic                       cmd_ready_r;
  logic                       rsp_valid_r;
  logic [DATA_WIDTH-1:0]      rsp_rdata_r;
  logic [1:0]                 rsp_resp_r;
  logic [ADDRESS_WIDTH-1:0]   awaddr_r;
  logic                       awvalid_r;
  logic [DATA_WIDTH-1:0]      wdata_r;
  logic [DATA_WIDTH/8-1:0]    wstrb_r;
  logic                       wvalid_r;
  logic                       bready_r;
  logic [ADDRESS_WIDTH-1:0]   araddr_r;
  logic                       arvalid_r;
  logic                       rready_r;

  // A channel counts as finished once its valid has dropped, or when it
  // handshakes in the current cycle; both must be true to leave WR_ADDR_DATA.
  logic aw_done_s;
  logic w_done_s;
  assign aw_done_s = !awvalid_r || axi_awready_in;
  assign w_done_s  = !wvalid_r  || axi_wready_in;

  // Transaction sequencer: state plus every registered output.
  always_ff @(posedge axi_aclk_in) begin
    if (axi_areset_in) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_resp_r  <= 2'b00;
      awaddr_r    <= '0;
      awvalid_r   <= 1'b0;
      wdata_r     <= '0;
      wstrb_r     <= '0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      araddr_r    <= '0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid_in && cmd_ready_r) begin
            cmd_ready_r <= 1'b0;
            if (cmd_write_in) begin
              awaddr_r  <= cmd_addr_in;
              wdata_r   <= cmd_wdata_in;
              wstrb_r   <= cmd_wstrb_in;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              state_r   <= WR_ADDR_DATA;
            end else begin
              araddr_r  <= cmd_addr_in;
              arvalid_r <= 1'b1;
              state_r   <= RD_ADDR;
            end
          end else begin
            // Also raises ready on the first idle cycle after reset.
            cmd_ready_r <= 1'b1;
          end
        end

        WR_ADDR_DATA: begin
          if (awvalid_r && axi_awready_in) begin
            awvalid_r <= 1'b0;
          end
          if (wvalid_r && axi_wready_in) begin
            wvalid_r <= 1'b0;
          end
          if (aw_done_s && w_done_s) begin
            bready_r <= 1'b1;
            state_r  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (axi_bvalid_in && bready_r) begin
            rsp_resp_r  <= axi_bresp_in;
            rsp_rdata_r <= '0;
            bready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= RESPOND;
          end
        end

        RD_ADDR: begin
          if (axi_arready_in) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (axi_rvalid_in && rready_r) begin
            rsp_rdata_r <= axi_rdata_in;
            rsp_resp_r  <= axi_rresp_in;
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= RESPOND;
          end
        end

        RESPOND: begin
          if (rsp_ready_in) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end

        default: begin
          // Unreachable encodings recover to a quiet idle bus.
          state_r     <= IDLE;
          cmd_ready_r <= 1'b0;
          rsp_valid_r <= 1'b0;
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
          arvalid_r   <= 1'b0;
          rready_r    <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_out   = cmd_ready_r;
  assign rsp_valid_out   = rsp_valid_r;
  assign rsp_rdata_out   = rsp_rdata_r;
  assign rsp_resp_out    = rsp_resp_r;
  assign axi_awaddr_out  = awaddr_r;
  assign axi_awprot_out  = PROT;
  assign axi_awvalid_out = awvalid_r;
  assign axi_wdata_out   = wdata_r;
  assign axi_wstrb_out   = wstrb_r;
  assign axi_wvalid_out  = wvalid_r;
  assign axi_bready_out  = bready_r;
  assign axi_araddr_out  = araddr_r;
  assign axi_arprot_out  = PROT;
  assign axi_arvalid_out = arvalid_r;
  assign axi_rready_out  = rready_r;

endmodule

// File: tb/tb_axi_lite_manager.sv
module tb_axi_lite_manager;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid_in = 1'b0;
  logic        cmd_ready_out;
  logic        cmd_write_in = 1'b0;
  logic [3:0]  cmd_addr_in = 4'd0;
  logic [31:0] cmd_wdata_in = 32'd0;
  logic [3:0]  cmd_wstrb_in = 4'd0;
  logic        rsp_valid_out;
  logic        rsp_ready_in = 1'b0;
  logic [31:0] rsp_rdata_out;
  logic [1:0]  rsp_resp_out;
  logic [3:0]  axi_awaddr_out;
  logic [2:0]  axi_awprot_out;
  logic        axi_awvalid_out;
  logic        axi_awready_in = 1'b0;
  logic [31:0] axi_wdata_out;
  logic [3:0]  axi_wstrb_out;
  logic        axi_wvalid_out;
  logic        axi_wready_in = 1'b0;
  logic [1:0]  axi_bresp_in = 2'b00;
  logic        axi_bvalid_in = 1'b0;
  logic        axi_bready_out;
  logic [3:0]  axi_araddr_out;
  logic [2:0]  axi_arprot_out;
  logic        axi_arvalid_out;
  logic        axi_arready_in = 1'b0;
  logic [31:0] axi_rdata_in = 32'd0;
  logic [1:0]  axi_rresp_in = 2'b00;
  logic        axi_rvalid_in = 1'b0;
  logic        axi_rready_out;

  axi_lite_manager dut (
    .axi_aclk_in(clk), .axi_areset_in(rst),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_write_in(cmd_write_in), .cmd_addr_in(cmd_addr_in),
    .cmd_wdata_in(cmd_wdata_in), .cmd_wstrb_in(cmd_wstrb_in),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
    .rsp_rdata_out(rsp_rdata_out), .rsp_resp_out(rsp_resp_out),
    .axi_awaddr_out(axi_awaddr_out), .axi_awprot_out(axi_awprot_out),
    .axi_awvalid_out(axi_awvalid_out), .axi_awready_in(axi_awready_in),
    .axi_wdata_out(axi_wdata_out), .axi_wstrb_out(axi_wstrb_out),
    .axi_wvalid_out(axi_wvalid_out), .axi_wready_in(axi_wready_in),
    .axi_bresp_in(axi_bresp_in), .axi_bvalid_in(axi_bvalid_in),
    .axi_bready_out(axi_bready_out),
    .axi_araddr_out(axi_araddr_out), .axi_arprot_out(axi_arprot_out),
    .axi_arvalid_out(axi_arvalid_out), .axi_arready_in(axi_arready_in),
    .axi_rdata_in(axi_rdata_in), .axi_rresp_in(axi_rresp_in),
    .axi_rvalid_in(axi_rvalid_in), .axi_rready_out(axi_rready_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register contents as the command side expects them.
  logic [31:0] ref_mem [4];
  // Subordinate storage, written only through the AXI write channels.
  logic [31:0] sub_mem [4];

  // Subordinate configuration: -1 means random delay up to max_delay.
  int max_delay = 0;
  int aw_dly = -1, w_dly = -1, ar_dly = -1, b_dly = -1, r_dly = -1;
  logic [1:0] cur_resp = 2'b00;
  logic [3:0]  exp_addr = 4'd0;
  logic [31:0] exp_wdata = 32'd0;
  logic [3:0]  exp_wstrb = 4'd0;

  // Subordinate state.
  bit got_aw, got_w, got_ar, b_pend, r_pend;
  bit aw_seen, w_seen, ar_seen;
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  logic [3:0]  s_awaddr, s_araddr;
  logic [31:0] s_wdata, r_word;
  logic [3:0]  s_wstrb;
  int aw_hi, w_hi;
  // Previous-cycle observations for hold/stability checks.
  bit p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs;
  logic [3:0]  p_awaddr, p_araddr;
  logic [31:0] p_wdata;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(input int cfg);
    if (cfg >= 0) return cfg;
    return int'($urandom_range(32'(max_delay), 32'd0));
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic clear_sub();
    got_aw = 0; got_w = 0; got_ar = 0; b_pend = 0; r_pend = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0;
    p_awv = 0; p_awhs = 0; p_wv = 0; p_whs = 0; p_arv = 0; p_arhs = 0;
    axi_awready_in = 1'b0; axi_wready_in = 1'b0; axi_arready_in = 1'b0;
    axi_bvalid_in = 1'b0; axi_rvalid_in = 1'b0;
  endtask

  // One clock: at the falling edge, check the bus and drive the subordinate.
  task automatic tick();
    logic [31:0] junk;
    @(negedge clk);
    junk = $urandom;
    if (got_aw && got_w && !b_pend) begin
      sub_mem[s_awaddr[3:2]] = (sub_mem[s_awaddr[3:2]] & ~strb_mask(s_wstrb)) | (s_wdata & strb_mask(s_wstrb));
      b_pend = 1; b_wait = pick(b_dly);
    end
    if (got_ar && !r_pend) begin
      r_pend = 1; got_ar = 0; r_wait = pick(r_dly); r_word = sub_mem[s_araddr[3:2]];
    end
    if (p_awv) begin
      if (p_awhs) check_eq("awvalid_drop", 32'(axi_awvalid_out), 32'd0);
      else begin
        check_eq("awvalid_hold", 32'(axi_awvalid_out), 32'd1);
        check_eq("awaddr_stable", 32'(axi_awaddr_out), 32'(p_awaddr));
      end
    end
    if (p_wv) begin
      if (p_whs) check_eq("wvalid_drop", 32'(axi_wvalid_out), 32'd0);
      else begin
        check_eq("wvalid_hold", 32'(axi_wvalid_out), 32'd1);
        check_eq("wdata_stable", axi_wdata_out, p_wdata);
      end
    end
    if (p_arv) begin
      if (p_arhs) check_eq("arvalid_drop", 32'(axi_arvalid_out), 32'd0);
      else begin
        check_eq("arvalid_hold", 32'(axi_arvalid_out), 32'd1);
        check_eq("araddr_stable", 32'(axi_araddr_out), 32'(p_araddr));
      end
    end
    if (axi_bready_out) check_eq("bready_early", 32'(got_aw && got_w), 32'd1);
    if (axi_rready_out) check_eq("rready_early", 32'(r_pend), 32'd1);
    if (axi_awvalid_out) aw_hi++;
    if (axi_wvalid_out) w_hi++;
    // write address channel
    axi_awready_in = 1'b0;
    if (axi_awvalid_out && !got_aw) begin
      if (!aw_seen) begin aw_seen = 1; aw_wait = pick(aw_dly); end
      if (aw_wait == 0) begin
        axi_awready_in = 1'b1; got_aw = 1; aw_seen = 0; s_awaddr = axi_awaddr_out;
        check_eq("awaddr", 32'(axi_awaddr_out), 32'(exp_addr));
        check_eq("awprot", 32'(axi_awprot_out), 32'd0);
      end else aw_wait--;
    end
    // write data channel
    axi_wready_in = 1'b0;
    if (axi_wvalid_out && !got_w) begin
      if (!w_seen) begin w_seen = 1; w_wait = pick(w_dly); end
      if (w_wait == 0) begin
        axi_wready_in = 1'b1; got_w = 1; w_seen = 0; s_wdata = axi_wdata_out; s_wstrb = axi_wstrb_out;
        check_eq("wdata", axi_wdata_out, exp_wdata);
        check_eq("wstrb", 32'(axi_wstrb_out), 32'(exp_wstrb));
      end else w_wait--;
    end
    // read address channel
    axi_arready_in = 1'b0;
    if (axi_arvalid_out && !got_ar && !r_pend) begin
      if (!ar_seen) begin ar_seen = 1; ar_wait = pick(ar_dly); end
      if (ar_wait == 0) begin
        axi_arready_in = 1'b1; got_ar = 1; ar_seen = 0; s_araddr = axi_araddr_out;
        check_eq("araddr", 32'(axi_araddr_out), 32'(exp_addr));
        check_eq("arprot", 32'(axi_arprot_out), 32'd0);
      end else ar_wait--;
    end
    // write response channel
    axi_bvalid_in = 1'b0; axi_bresp_in = junk[1:0];
    if (b_pend) begin
      if (b_wait == 0) begin
        axi_bvalid_in = 1'b1; axi_bresp_in = cur_resp;
        if (axi_bready_out) begin b_pend = 0; got_aw = 0; got_w = 0; end
      end else b_wait--;
    end
    // read data channel
    axi_rvalid_in = 1'b0; axi_rdata_in = junk; axi_rresp_in = junk[3:2];
    if (r_pend) begin
      if (r_wait == 0) begin
        axi_rvalid_in = 1'b1; axi_rdata_in = r_word; axi_rresp_in = cur_resp;
        if (axi_rready_out) r_pend = 0;
      end else r_wait--;
    end
    p_awv = axi_awvalid_out; p_awhs = axi_awvalid_out && axi_awready_in; p_awaddr = axi_awaddr_out;
    p_wv = axi_wvalid_out;   p_whs = axi_wvalid_out && axi_wready_in;    p_wdata = axi_wdata_out;
    p_arv = axi_arvalid_out; p_arhs = axi_arvalid_out && axi_arready_in; p_araddr = axi_araddr_out;
  endtask

  // Issue one command, collect its response and compare with the model.
  task automatic run_txn(input bit wr, input logic [3:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [1:0] resp, input int hold,
                         input bit chk_lat);
    int n;
    logic [31:0] exp_rdata;
    logic [31:0] junk;
    cur_resp = resp; exp_addr = addr; exp_wdata = data; exp_wstrb = strb;
    aw_hi = 0; w_hi = 0;
    n = 0;
    while (!cmd_ready_out && n < 20) begin tick(); n++; end
    check_eq("cmd_ready_idle", 32'(cmd_ready_out), 32'd1);
    cmd_valid_in = 1'b1; cmd_write_in = wr; cmd_addr_in = addr;
    cmd_wdata_in = data; cmd_wstrb_in = strb;
    exp_rdata = wr ? 32'd0 : ref_mem[addr[3:2]];
    tick();
    check_eq("aw_latency", 32'(axi_awvalid_out), 32'(wr));
    check_eq("w_latency", 32'(axi_wvalid_out), 32'(wr));
    check_eq("ar_latency", 32'(axi_arvalid_out), 32'(!wr));
    // Keep offering garbage commands; none may be accepted while busy.
    junk = $urandom;
    cmd_write_in = junk[0]; cmd_addr_in = junk[7:4]; cmd_wdata_in = ~junk; cmd_wstrb_in = junk[11:8];
    n = 1;
    while (!rsp_valid_out && n < 200) begin
      check_eq("cmd_ready_busy", 32'(cmd_ready_out), 32'd0);
      tick(); n++;
    end
    check_eq("rsp_valid_seen", 32'(rsp_valid_out), 32'd1);
    if (chk_lat) check_eq("turnaround", 32'(n), 32'd3);
    for (int h = 0; h <= hold; h++) begin
      check_eq("rsp_valid_hold", 32'(rsp_valid_out), 32'd1);
      check_eq("rsp_rdata", rsp_rdata_out, exp_rdata);
      check_eq("rsp_resp", 32'(rsp_resp_out), 32'(resp));
      check_eq("cmd_ready_respond", 32'(cmd_ready_out), 32'd0);
      check_eq("axi_quiet", 32'({axi_awvalid_out, axi_wvalid_out, axi_arvalid_out, axi_bready_out, axi_rready_out}), 32'd0);
      if (h == hold) rsp_ready_in = 1'b1;
      tick();
    end
    rsp_ready_in = 1'b0; cmd_valid_in = 1'b0;
    check_eq("rsp_valid_drop", 32'(rsp_valid_out), 32'd0);
    check_eq("cmd_ready_after", 32'(cmd_ready_out), 32'd1);
    if (wr) ref_mem[addr[3:2]] = (ref_mem[addr[3:2]] & ~strb_mask(strb)) | (data & strb_mask(strb));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rnd;
    int n;
    for (int i = 0; i < 4; i++) begin ref_mem[i] = 32'd0; sub_mem[i] = 32'd0; end
    clear_sub();
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_cmd_ready", 32'(cmd_ready_out), 32'd0);
    check_eq("rst_valids", 32'({rsp_valid_out, axi_awvalid_out, axi_wvalid_out, axi_arvalid_out, axi_bready_out, axi_rready_out}), 32'd0);
    check_eq("rst_rdata", rsp_rdata_out, 32'd0);
    check_eq("rst_resp", 32'(rsp_resp_out), 32'd0);
    rst = 1'b0;
    tick();

    // Minimum-latency write, all readies immediate.
    max_delay = 0;
    run_txn(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 2'b00, 0, 1'b1);

    // AW ready delayed three cycles, W ready immediate.
    aw_dly = 3; w_dly = 0;
    run_txn(1'b1, 4'h0, 32'hCAFEF00D, 4'hF, 2'b00, 0, 1'b0);
    check_eq("aw_high_cycles", 32'(aw_hi), 32'd4);
    check_eq("w_high_cycles", 32'(w_hi), 32'd1);
    aw_dly = -1; w_dly = -1;

    // Read with slow AR and an SLVERR response.
    run_txn(1'b1, 4'h8, 32'h12345678, 4'hF, 2'b00, 0, 1'b1);
    ar_dly = 2;
    run_txn(1'b0, 4'h8, 32'h0, 4'h0, 2'b10, 0, 1'b0);
    ar_dly = -1;
    run_txn(1'b0, 4'h8, 32'h0, 4'h0, 2'b00, 0, 1'b1);

    // Response held off for five cycles while commands keep arriving.
    run_txn(1'b1, 4'h4, 32'h0BADF00D, 4'h5, 2'b11, 5, 1'b0);

    // Reset in the middle of a pending write.
    aw_dly = 8; w_dly = 8;
    n = 0;
    while (!cmd_ready_out && n < 20) begin tick(); n++; end
    exp_addr = 4'h4; exp_wdata = 32'h11111111; exp_wstrb = 4'hF;
    cmd_valid_in = 1'b1; cmd_write_in = 1'b1; cmd_addr_in = 4'h4;
    cmd_wdata_in = 32'h11111111; cmd_wstrb_in = 4'hF;
    tick();
    cmd_valid_in = 1'b0;
    tick();
    check_eq("aw_pending", 32'(axi_awvalid_out), 32'd1);
    rst = 1'b1;
    clear_sub();
    tick();
    check_eq("midrst_valids", 32'({rsp_valid_out, axi_awvalid_out, axi_wvalid_out, axi_arvalid_out, axi_bready_out, axi_rready_out}), 32'd0);
    check_eq("midrst_cmd_ready", 32'(cmd_ready_out), 32'd0);
    rst = 1'b0;
    aw_dly = -1; w_dly = -1;
    tick();
    check_eq("post_rst_cmd_ready", 32'(cmd_ready_out), 32'd1);
    run_txn(1'b1, 4'h0, 32'h01020304, 4'hF, 2'b00, 0, 1'b1);
    run_txn(1'b0, 4'h4, 32'h0, 4'h0, 2'b00, 0, 1'b1);

    // Back-to-back write then read of the same register.
    run_txn(1'b1, 4'hC, 32'hA5A5A5A5, 4'hF, 2'b00, 0, 1'b1);
    run_txn(1'b0, 4'hC, 32'h0, 4'h0, 2'b00, 0, 1'b1);

    // Random traffic with random subordinate delays and response codes.
    max_delay = 4;
    for (int t = 0; t < 60; t++) begin
      rnd = $urandom;
      run_txn(rnd[0], rnd[7:4], $urandom, rnd[11:8], rnd[13:12], int'(rnd[15:14]), 1'b0);
    end
    for (int a = 0; a < 4; a++) begin
      rnd = 32'(a * 4);
      run_txn(1'b0, rnd[3:0], 32'h0, 4'h0, 2'b00, 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
